// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FIFO.
// Holds pointer sizing and the parameter-legality predicate.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(
    input int depth,
    input int afull,
    input int aempty
  );
    return (depth >= 4)
      && ((depth & (depth - 1)) == 0)
      && (afull >= 1) && (afull <= depth)
      && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifomem.sv
// FIFO storage array with a registered, enable-gated read port.
// Array contents are never reset; only the read register is.
module fifomem #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 7
) (
  input  logic                wclk,
  input  logic                wen,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rclk,
  input  logic                rst,
  input  logic                ren,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge wclk) begin
    if (wen) mem[waddr] <= wdata;
  end

  always_ff @(posedge rclk) begin
    if (rst)      rdata <= '0;
    else if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// exact fill level, programmable thresholds and sticky error flags.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 128,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             winc,
  input  logic [FIFO_WIDTH-1:0]            wdata,
  output logic                             wfull,
  output logic                             walmost_full,
  input  logic                             rinc,
  output logic [FIFO_WIDTH-1:0]            rdata,
  output logic                             rempty,
  output logic                             ralmost_empty,
  output logic [$clog2(FIFO_DEPTH):0]      level,
  input  logic                             clr_err,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = ptr_w(FIFO_DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_LVL = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_LVL = LW'(AEMPTY_THRESH);

  if (!params_ok(FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("sync_fifo_prog: illegal depth or threshold parameters");
  end

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wren;
  logic          rden;
  logic          ren;

  assign wren = winc & ~wfull;
  assign rden = rinc & ~rempty;

  assign wfull         = (level == FULL_LVL);
  assign walmost_full  = (level >= AF_LVL);
  assign ralmost_empty = (level <= AE_LVL);

  if (MODE == FIFO_FWFT) begin : g_fwft
    logic          ovalid;
    logic [LW-1:0] mem_cnt;

    // level includes the word parked in the output register
    assign mem_cnt = level - {{(LW-1){1'b0}}, ovalid};
    assign ren     = (~ovalid | rden) & (mem_cnt != '0);
    assign rempty  = ~ovalid;

    always_ff @(posedge clk) begin
      if (rst)       ovalid <= 1'b0;
      else if (ren)  ovalid <= 1'b1;
      else if (rden) ovalid <= 1'b0;
    end
  end else begin : g_std
    assign ren    = rden;
    assign rempty = (level == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wren) wptr <= wptr + AW'(1);
      if (ren)  rptr <= rptr + AW'(1);
      unique case ({wren, rden})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // a new error event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc & wfull) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rinc & rempty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  fifomem #(
    .DATASIZE(FIFO_WIDTH),
    .ADDRSIZE(AW)
  ) u_mem (
    .wclk  (clk),
    .wen   (wren),
    .waddr (wptr),
    .wdata (wdata),
    .rclk  (clk),
    .rst   (rst),
    .ren   (ren),
    .raddr (rptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog in standard and FWFT modes.
// Two depth-8 instances share one clock and reset.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_winc, s_rinc, s_clr;
  logic [15:0] s_wdata, s_rdata;
  logic        s_wfull, s_afull, s_rempty, s_aempty, s_ovf, s_udf;
  logic [3:0]  s_level;

  logic        f_winc, f_rinc, f_clr;
  logic [15:0] f_wdata, f_rdata;
  logic        f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_udf;
  logic [3:0]  f_level;

  int checks = 0;
  int failures = 0;
  logic [15:0] sq[$];
  logic [15:0] fq[$];
  logic [15:0] exp;

  sync_fifo_prog #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0),
    .AFULL_THRESH(4), .AEMPTY_THRESH(2)
  ) u_std (
    .clk(clk), .rst(rst),
    .winc(s_winc), .wdata(s_wdata),
    .wfull(s_wfull), .walmost_full(s_afull),
    .rinc(s_rinc), .rdata(s_rdata),
    .rempty(s_rempty), .ralmost_empty(s_aempty),
    .level(s_level), .clr_err(s_clr),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_prog #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1),
    .AFULL_THRESH(4), .AEMPTY_THRESH(2)
  ) u_fw (
    .clk(clk), .rst(rst),
    .winc(f_winc), .wdata(f_wdata),
    .wfull(f_wfull), .walmost_full(f_afull),
    .rinc(f_rinc), .rdata(f_rdata),
    .rempty(f_rempty), .ralmost_empty(f_aempty),
    .level(f_level), .clr_err(f_clr),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_winc = 0; s_rinc = 0; s_clr = 0; s_wdata = '0;
    f_winc = 0; f_rinc = 0; f_clr = 0; f_wdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (s_level !== 4'd0) begin
      failures++; $display("FAIL reset_level got=%0d exp=0", s_level);
    end
    checks++;
    if ({s_rempty, s_aempty, s_wfull, s_afull} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1100",
        {s_rempty, s_aempty, s_wfull, s_afull});
    end
    checks++;
    if ({s_ovf, s_udf} !== 2'b00) begin
      failures++; $display("FAIL reset_err got=%b exp=00", {s_ovf, s_udf});
    end
    checks++;
    if (s_rdata !== 16'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0000", s_rdata);
    end
    checks++;
    if ({f_rempty, f_aempty, f_level} !== {2'b11, 4'd0}) begin
      failures++;
      $display("FAIL reset_fwft got=%b exp=110000",
        {f_rempty, f_aempty, f_level});
    end
    checks++;
    if (f_rdata !== 16'h0) begin
      failures++; $display("FAIL reset_fwft_rdata got=%h exp=0000", f_rdata);
    end
  endtask

  task automatic fill_std(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_winc = 1'b1;
      s_wdata = base + 16'(i);
      sq.push_back(s_wdata);
      step();
    end
    s_winc = 1'b0;
  endtask

  task automatic test_std_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      s_winc = 1'b1;
      s_wdata = 16'(i);
      sq.push_back(s_wdata);
      step();
      checks++;
      if (s_level !== 4'(i)) begin
        failures++; $display("FAIL fill_level got=%0d exp=%0d", s_level, i);
      end
      checks++;
      if (s_afull !== (i >= 4)) begin
        failures++;
        $display("FAIL fill_afull lvl=%0d got=%b exp=%b", i, s_afull, i >= 4);
      end
      checks++;
      if (s_aempty !== (i <= 2)) begin
        failures++;
        $display("FAIL fill_aempty lvl=%0d got=%b exp=%b", i, s_aempty, i <= 2);
      end
    end
    s_winc = 1'b0;
    checks++;
    if (s_wfull !== 1'b1) begin
      failures++; $display("FAIL fill_wfull got=%b exp=1", s_wfull);
    end
    for (int i = 0; i < 8; i++) begin
      s_rinc = 1'b1;
      step();
      exp = sq.pop_front();
      checks++;
      if (s_rdata !== exp) begin
        failures++; $display("FAIL drain_data got=%h exp=%h", s_rdata, exp);
      end
      checks++;
      if (s_level !== 4'(7 - i)) begin
        failures++; $display("FAIL drain_level got=%0d exp=%0d", s_level, 7 - i);
      end
    end
    s_rinc = 1'b0;
    checks++;
    if ({s_rempty, s_udf} !== 2'b10) begin
      failures++; $display("FAIL drain_end got=%b exp=10", {s_rempty, s_udf});
    end
    step();
    checks++;
    if (s_rdata !== 16'h0008) begin
      failures++; $display("FAIL rdata_hold got=%h exp=0008", s_rdata);
    end
  endtask

  task automatic test_full_simul();
    fill_std(16'h0100, 8);
    s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 16'hDEAD;
    step();
    s_winc = 1'b0; s_rinc = 1'b0;
    exp = sq.pop_front();
    checks++;
    if (s_level !== 4'd7) begin
      failures++; $display("FAIL fullrw_level got=%0d exp=7", s_level);
    end
    checks++;
    if (s_rdata !== exp) begin
      failures++; $display("FAIL fullrw_data got=%h exp=%h", s_rdata, exp);
    end
    checks++;
    if ({s_ovf, s_udf} !== 2'b10) begin
      failures++; $display("FAIL fullrw_err got=%b exp=10", {s_ovf, s_udf});
    end
    s_rinc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      exp = sq.pop_front();
      checks++;
      if (s_rdata !== exp) begin
        failures++; $display("FAIL fullrw_drain got=%h exp=%h", s_rdata, exp);
      end
    end
    s_rinc = 1'b0;
    checks++;
    if (s_rempty !== 1'b1) begin
      failures++; $display("FAIL fullrw_empty got=%b exp=1", s_rempty);
    end
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    checks++;
    if (s_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%b exp=0", s_ovf);
    end
  endtask

  task automatic test_underflow();
    s_rinc = 1'b1;
    step();
    s_rinc = 1'b0;
    checks++;
    if (s_udf !== 1'b1) begin
      failures++; $display("FAIL udf_set got=%b exp=1", s_udf);
    end
    step(); step();
    checks++;
    if (s_udf !== 1'b1) begin
      failures++; $display("FAIL udf_sticky got=%b exp=1", s_udf);
    end
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    checks++;
    if (s_udf !== 1'b0) begin
      failures++; $display("FAIL udf_clear got=%b exp=0", s_udf);
    end
    s_clr = 1'b1; s_rinc = 1'b1;
    step();
    s_clr = 1'b0; s_rinc = 1'b0;
    checks++;
    if (s_udf !== 1'b1) begin
      failures++; $display("FAIL udf_set_wins got=%b exp=1", s_udf);
    end
    checks++;
    if (s_level !== 4'd0) begin
      failures++; $display("FAIL udf_level got=%0d exp=0", s_level);
    end
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
  endtask

  task automatic test_fwft_single();
    f_winc = 1'b1; f_wdata = 16'hBEEF;
    step();
    f_winc = 1'b0;
    checks++;
    if ({f_rempty, f_level} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL fwft_edgeN got=%b/%0d exp=1/1", f_rempty, f_level);
    end
    step();
    checks++;
    if ({f_rempty, f_rdata} !== {1'b0, 16'hBEEF}) begin
      failures++;
      $display("FAIL fwft_edgeN1 got=%b/%h exp=0/beef", f_rempty, f_rdata);
    end
    f_rinc = 1'b1;
    step();
    f_rinc = 1'b0;
    checks++;
    if ({f_rempty, f_level, f_udf} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL fwft_pop got=%b/%0d/%b exp=1/0/0",
        f_rempty, f_level, f_udf);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      f_winc = 1'b1;
      f_wdata = 16'hA0 + 16'(i);
      fq.push_back(f_wdata);
      step();
    end
    f_winc = 1'b0;
    checks++;
    if ({f_wfull, f_level} !== {1'b1, 4'd8}) begin
      failures++;
      $display("FAIL fwft_full got=%b/%0d exp=1/8", f_wfull, f_level);
    end
    f_rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = fq.pop_front();
      checks++;
      if ({f_rempty, f_rdata} !== {1'b0, exp}) begin
        failures++;
        $display("FAIL fwft_stream got=%b/%h exp=0/%h", f_rempty, f_rdata, exp);
      end
      step();
    end
    f_rinc = 1'b0;
    checks++;
    if ({f_rempty, f_level} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL fwft_stream_end got=%b/%0d exp=1/0", f_rempty, f_level);
    end
  endtask

  task automatic test_reset_mid();
    fill_std(16'h0050, 5);
    checks++;
    if (s_level !== 4'd5) begin
      failures++; $display("FAIL mid_level got=%0d exp=5", s_level);
    end
    sq.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({s_level, s_rempty, s_rdata} !== {4'd0, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%b/%h exp=0/1/0000",
        s_level, s_rempty, s_rdata);
    end
    fill_std(16'h1234, 1);
    s_rinc = 1'b1;
    step();
    s_rinc = 1'b0;
    exp = sq.pop_front();
    checks++;
    if (s_rdata !== exp) begin
      failures++; $display("FAIL mid_stale got=%h exp=%h", s_rdata, exp);
    end
    checks++;
    if (s_rempty !== 1'b1) begin
      failures++; $display("FAIL mid_empty got=%b exp=1", s_rempty);
    end
  endtask

  initial begin
    test_reset();
    test_std_fill_drain();
    test_full_simul();
    test_underflow();
    test_fwft_single();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
